// File: rtl/scaler_v_line_sched.sv
// scaler_v_line_sched
//   Vertical line scheduler for the bilinear scaler. It counts the input lines
//   that have landed in the line buffers and steps a fixed-point vertical phase
//   accumulator. For each output line it issues one request to the datapath,
//   carrying the top source line y0 and the weight of line y0+1. The request
//   is held until the datapath acknowledges it.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   reg_v_scale_step  vertical step (SCALE_STEP = 1:1, 0 treated as 1:1)
//   reg_v_in_lines    number of input lines minus 1
//   hs_i, vs_i        input sync: hs high in blanking, vs high in active frame
//   line_req_o        output-line request, held until line_done_i
//   line_idx_o        top source line y0 of the request
//   line_coe_o        weight of line y0+1
//   line_last_o       y0 is the last input line (both taps use y0)
//   line_done_i       datapath finished the requested line (1-cycle pulse)
//   frame_done_o      1-cycle pulse after the final output line of a frame
//   out_line_cnt_o    output lines completed in the current frame
//   err_o             1-cycle pulse when a frame restarts before finishing
module scaler_v_line_sched #(
  parameter int SCALE_STEP     = 128,
  parameter int COE_WIDTH      = 8,
  parameter int LINE_CNT_WIDTH = 12,
  parameter int STEP_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [STEP_WIDTH-1:0]     reg_v_scale_step,
  input  logic [LINE_CNT_WIDTH-1:0] reg_v_in_lines,
  input  logic                      hs_i,
  input  logic                      vs_i,
  output logic                      line_req_o,
  output logic [LINE_CNT_WIDTH-1:0] line_idx_o,
  output logic [COE_WIDTH-1:0]      line_coe_o,
  output logic                      line_last_o,
  input  logic                      line_done_i,
  output logic                      frame_done_o,
  output logic [LINE_CNT_WIDTH-1:0] out_line_cnt_o,
  output logic                      err_o
);

  localparam int FRAC  = $clog2(SCALE_STEP);
  localparam int ACC_W = STEP_WIDTH + FRAC;
  // Compare width: wide enough for y0+2 and in_lines+1 without wrapping
  // (STEP_WIDTH exceeds LINE_CNT_WIDTH).
  localparam int CMP_W = STEP_WIDTH + 2;
  localparam int ICW   = LINE_CNT_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_t;

  state_t                    r_state, w_state_nx;
  logic                      r_sr_hs, r_sr_vs;
  logic [STEP_WIDTH-1:0]     r_step, w_step_nx;
  logic [LINE_CNT_WIDTH-1:0] r_in_lines, w_in_lines_nx;
  logic [ACC_W-1:0]          r_acc, w_acc_nx;
  logic [ICW-1:0]            r_in_cnt, w_in_cnt_nx;
  logic [LINE_CNT_WIDTH-1:0] r_out_cnt, w_out_cnt_nx;
  logic                      r_req, w_req_nx;
  logic [LINE_CNT_WIDTH-1:0] r_idx, w_idx_nx;
  logic [COE_WIDTH-1:0]      r_coe, w_coe_nx;
  logic                      r_last, w_last_nx;
  logic                      r_frame_done, w_frame_done_nx;
  logic                      r_err, w_err_nx;

  logic                          w_frame_start, w_line_end;
  logic [STEP_WIDTH-1:0]         w_y0;
  logic [CMP_W-1:0]              w_y0_ext, w_in_lines_ext, w_lines_total, w_in_cnt_ext;
  logic                          w_past_end, w_ready, w_last;
  logic [FRAC+COE_WIDTH-1:0]     w_frac_cat;
  logic [COE_WIDTH-1:0]          w_coe;

  assign w_frame_start  = vs_i & ~r_sr_vs;
  // sr_vs rather than vs_i qualifies the line end, so the last hs rise may
  // coincide with the vs fall.
  assign w_line_end     = hs_i & ~r_sr_hs & r_sr_vs;

  assign w_y0           = r_acc[ACC_W-1:FRAC];
  assign w_y0_ext       = CMP_W'(w_y0);
  assign w_in_lines_ext = CMP_W'(r_in_lines);
  assign w_lines_total  = w_in_lines_ext + CMP_W'(1);
  assign w_in_cnt_ext   = CMP_W'(r_in_cnt);
  assign w_past_end     = w_y0_ext > w_in_lines_ext;
  // Both taps y0 and y0+1 must be buffered, unless the whole frame is in.
  assign w_ready        = (w_in_cnt_ext >= w_y0_ext + CMP_W'(2)) ||
                          (w_in_cnt_ext == w_lines_total);
  assign w_last         = w_y0_ext == w_in_lines_ext;

  // Taking the top COE_WIDTH bits of {frac, zeros} rescales the fraction to
  // COE_WIDTH bits: a left shift when COE_WIDTH >= FRAC, a right shift otherwise.
  assign w_frac_cat     = {r_acc[FRAC-1:0], {COE_WIDTH{1'b0}}};
  assign w_coe          = w_last ? '0 : w_frac_cat[FRAC+COE_WIDTH-1:FRAC];

  always_comb begin
    w_state_nx      = r_state;
    w_step_nx       = r_step;
    w_in_lines_nx   = r_in_lines;
    w_acc_nx        = r_acc;
    w_in_cnt_nx     = r_in_cnt;
    w_out_cnt_nx    = r_out_cnt;
    w_req_nx        = r_req;
    w_idx_nx        = r_idx;
    w_coe_nx        = r_coe;
    w_last_nx       = r_last;
    w_frame_done_nx = 1'b0;
    w_err_nx        = 1'b0;

    if (w_line_end && (w_in_cnt_ext < w_lines_total)) begin
      w_in_cnt_nx = r_in_cnt + ICW'(1);
    end

    if (w_frame_start) begin
      w_step_nx     = (reg_v_scale_step == '0) ? STEP_WIDTH'(SCALE_STEP) : reg_v_scale_step;
      w_in_lines_nx = reg_v_in_lines;
      w_acc_nx      = '0;
      w_in_cnt_nx   = '0;
      w_out_cnt_nx  = '0;
      w_req_nx      = 1'b0;
      w_idx_nx      = '0;
      w_coe_nx      = '0;
      w_last_nx     = 1'b0;
      w_err_nx      = (r_state != S_IDLE);
      w_state_nx    = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_past_end) begin
            w_frame_done_nx = 1'b1;
            w_state_nx      = S_IDLE;
          end else if (w_ready) begin
            w_req_nx   = 1'b1;
            w_idx_nx   = w_y0[LINE_CNT_WIDTH-1:0];
            w_coe_nx   = w_coe;
            w_last_nx  = w_last;
            w_state_nx = S_REQ;
          end
        end
        S_REQ: begin
          if (line_done_i) begin
            w_req_nx     = 1'b0;
            w_last_nx    = 1'b0;
            w_acc_nx     = r_acc + ACC_W'(r_step);
            w_out_cnt_nx = r_out_cnt + LINE_CNT_WIDTH'(1);
            w_state_nx   = S_WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sr_hs      <= 1'b0;
      r_sr_vs      <= 1'b0;
      r_step       <= '0;
      r_in_lines   <= '0;
      r_acc        <= '0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_req        <= 1'b0;
      r_idx        <= '0;
      r_coe        <= '0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_sr_hs      <= hs_i;
      r_sr_vs      <= vs_i;
      r_step       <= w_step_nx;
      r_in_lines   <= w_in_lines_nx;
      r_acc        <= w_acc_nx;
      r_in_cnt     <= w_in_cnt_nx;
      r_out_cnt    <= w_out_cnt_nx;
      r_req        <= w_req_nx;
      r_idx        <= w_idx_nx;
      r_coe        <= w_coe_nx;
      r_last       <= w_last_nx;
      r_frame_done <= w_frame_done_nx;
      r_err        <= w_err_nx;
    end
  end

  assign line_req_o     = r_req;
  assign line_idx_o     = r_idx;
  assign line_coe_o     = r_coe;
  assign line_last_o    = r_last;
  assign frame_done_o   = r_frame_done;
  assign out_line_cnt_o = r_out_cnt;
  assign err_o          = r_err;

endmodule

// File: tb/tb_scaler_v_line_sched.sv
`timescale 1ns/1ps
module tb_scaler_v_line_sched;
  localparam int SW = 16;
  localparam int LW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] reg_v_scale_step = '0;
  logic [LW-1:0] reg_v_in_lines = '0;
  logic          hs_i = 1'b1;
  logic          vs_i = 1'b0;
  logic          line_req_o;
  logic [LW-1:0] line_idx_o;
  logic [CW-1:0] line_coe_o;
  logic          line_last_o;
  logic          line_done_i = 1'b0;
  logic          frame_done_o;
  logic [LW-1:0] out_line_cnt_o;
  logic          err_o;

  scaler_v_line_sched #(
    .SCALE_STEP(128), .COE_WIDTH(CW), .LINE_CNT_WIDTH(LW), .STEP_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_v_scale_step(reg_v_scale_step), .reg_v_in_lines(reg_v_in_lines),
    .hs_i(hs_i), .vs_i(vs_i),
    .line_req_o(line_req_o), .line_idx_o(line_idx_o), .line_coe_o(line_coe_o),
    .line_last_o(line_last_o), .line_done_i(line_done_i),
    .frame_done_o(frame_done_o), .out_line_cnt_o(out_line_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] idx;
    logic [CW-1:0] coe;
    logic          last;
    int            min_lines;
  } req_t;

  req_t exp_q[$];
  int   exp_fd[$];

  int vectors = 0;
  int miscompares = 0;
  int tb_lines = 0;
  int fd_seen = 0;
  int err_seen = 0;
  int req_seen = 0;
  int done_delay = 2;
  bit rsp_en = 1'b1;

  // Datapath model: acknowledge each request done_delay cycles after it rises.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      line_done_i = 1'b0;
      if (rsp_en && rst_n && line_req_o) begin
        w++;
        if (w >= done_delay) begin
          line_done_i = 1'b1;
          w = 0;
        end
      end else begin
        w = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit            cur_v;
    logic [LW-1:0] cur_idx;
    logic [CW-1:0] cur_coe;
    logic          cur_last;
    req_t          e;
    int            efd;
    cur_v = 1'b0;
    cur_idx = '0;
    cur_coe = '0;
    cur_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_v = 1'b0;
      end else begin
        if (line_req_o && !cur_v) begin
          req_seen++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL req_unexpected got idx=%0d coe=%0d last=%0b, none expected",
                     line_idx_o, line_coe_o, line_last_o);
          end else begin
            e = exp_q.pop_front();
            if (line_idx_o !== e.idx || line_coe_o !== e.coe || line_last_o !== e.last ||
                tb_lines < e.min_lines) begin
              miscompares++;
              $display("FAIL req got idx=%0d coe=%0d last=%0b after %0d lines, want idx=%0d coe=%0d last=%0b after >=%0d lines",
                       line_idx_o, line_coe_o, line_last_o, tb_lines, e.idx, e.coe, e.last, e.min_lines);
            end
          end
          cur_v = 1'b1;
          cur_idx = line_idx_o;
          cur_coe = line_coe_o;
          cur_last = line_last_o;
        end else if (line_req_o) begin
          vectors++;
          if (line_idx_o !== cur_idx || line_coe_o !== cur_coe || line_last_o !== cur_last) begin
            miscompares++;
            $display("FAIL req_stable got idx=%0d coe=%0d last=%0b, want idx=%0d coe=%0d last=%0b",
                     line_idx_o, line_coe_o, line_last_o, cur_idx, cur_coe, cur_last);
          end
        end else begin
          cur_v = 1'b0;
        end
        if (frame_done_o) begin
          fd_seen++;
          vectors++;
          if (exp_fd.size() == 0) begin
            miscompares++;
            $display("FAIL frame_done_unexpected out_line_cnt=%0d", out_line_cnt_o);
          end else begin
            efd = exp_fd.pop_front();
            if (out_line_cnt_o !== LW'(efd)) begin
              miscompares++;
              $display("FAIL frame_done_cnt got %0d want %0d", out_line_cnt_o, efd);
            end
          end
        end
        if (err_o) err_seen++;
      end
    end
  end

  task automatic push(input int idx, input int coe, input bit last, input int minl);
    req_t r;
    r.idx = LW'(idx);
    r.coe = CW'(coe);
    r.last = last;
    r.min_lines = minl;
    exp_q.push_back(r);
  endtask

  task automatic start_frame(input int step, input int nl);
    @(negedge clk);
    reg_v_scale_step = SW'(step);
    reg_v_in_lines = LW'(nl);
    vs_i = 1'b1;
    tb_lines = 0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    vs_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_lines(input int n, input int active, input int blank);
    for (int i = 0; i < n; i++) begin
      hs_i = 1'b0;
      repeat (active) @(negedge clk);
      hs_i = 1'b1;
      tb_lines++;
      repeat (blank) @(negedge clk);
    end
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n;
    n = 0;
    while (fd_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (fd_seen < target) begin
      miscompares++;
      $display("FAIL frame_done_timeout seen=%0d want=%0d", fd_seen, target);
    end
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (!line_req_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!line_req_o) begin
      miscompares++;
      $display("FAIL req_timeout line_req_o=0 want 1");
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic push_unity_frame();
    push(0, 0, 0, 2); push(1, 0, 0, 3); push(2, 0, 0, 4); push(3, 0, 1, 4);
    exp_fd.push_back(4);
  endtask

  task automatic push_half_frame();
    push(0, 0, 0, 2);   push(0, 128, 0, 2);
    push(1, 0, 0, 3);   push(1, 128, 0, 3);
    push(2, 0, 0, 4);   push(2, 128, 0, 4);
    push(3, 0, 1, 4);   push(3, 0, 1, 4);
    exp_fd.push_back(8);
  endtask

  initial begin
    int rs;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({line_req_o, line_idx_o, line_coe_o, line_last_o,
                                 frame_done_o, out_line_cnt_o, err_o}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1:1, four input lines
    push_unity_frame();
    start_frame(128, 3);
    send_lines(4, 14, 6);
    wait_fd(1, 2000);
    check("t1_out_cnt", int'(out_line_cnt_o), 4);
    end_frame();

    // 2x upscale
    push_half_frame();
    start_frame(64, 3);
    send_lines(4, 14, 6);
    wait_fd(2, 2000);
    check("t2_out_cnt", int'(out_line_cnt_o), 8);
    end_frame();

    // 1.5x downscale, six input lines
    push(0, 0, 0, 2); push(1, 128, 0, 3); push(3, 0, 0, 5); push(4, 128, 0, 6);
    exp_fd.push_back(4);
    start_frame(192, 5);
    send_lines(6, 14, 6);
    wait_fd(3, 2000);
    check("t3_out_cnt", int'(out_line_cnt_o), 4);
    end_frame();

    // Slow datapath, extra input lines beyond the frame size
    done_delay = 500;
    push_half_frame();
    start_frame(64, 3);
    send_lines(6, 300, 60);
    wait_fd(4, 10000);
    end_frame();
    done_delay = 2;

    // Back-to-back frames, step 0 acts as 1:1
    push_unity_frame();
    start_frame(0, 3);
    send_lines(4, 14, 6);
    wait_fd(5, 2000);
    end_frame();
    push_unity_frame();
    start_frame(128, 3);
    send_lines(4, 14, 6);
    wait_fd(6, 2000);
    end_frame();
    check("no_err_yet", err_seen, 0);

    // Frame restart while a request is outstanding
    rsp_en = 1'b0;
    push(0, 0, 0, 2);
    start_frame(128, 3);
    send_lines(2, 14, 6);
    wait_req(100);
    @(negedge clk);
    vs_i = 1'b0;
    @(negedge clk);
    vs_i = 1'b1;
    tb_lines = 0;
    @(negedge clk);
    check("restart_err", int'(err_o), 1);
    check("restart_req_low", int'(line_req_o), 0);
    check("restart_out_cnt", int'(out_line_cnt_o), 0);
    repeat (3) @(negedge clk);
    check("err_pulse_count", err_seen, 1);

    // Asynchronous reset in the middle of a request
    push(0, 0, 0, 2);
    send_lines(2, 14, 6);
    wait_req(100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({line_req_o, line_idx_o, line_coe_o, line_last_o,
                                       frame_done_o, out_line_cnt_o, err_o}), 0);
    vs_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rsp_en = 1'b1;
    rs = req_seen;
    send_lines(3, 14, 6);
    repeat (10) @(negedge clk);
    check("idle_after_reset", req_seen, rs);

    // Recovery frame
    push_unity_frame();
    start_frame(128, 3);
    send_lines(4, 14, 6);
    wait_fd(7, 2000);
    end_frame();

    check("exp_req_left", exp_q.size(), 0);
    check("exp_fd_left", exp_fd.size(), 0);
    check("err_total", err_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
